dup_range_gen: RTL and testbench

Parameterizable streaming range generator, a hardware equivalent of a Python generator over `range(base, limit, step)`. It emits one element per accepted cycle on a valid/ready output stream and signals completion with `_done`. `DUP=0` gives the `hrange` behaviour: each value appears on both `_0` and `_1`. `DUP=1` gives the `dup_range_goal` behaviour: each value appears twice in succession on `_0`. The block sits as a leaf source feeding downstream stream consumers.

---
 rtl/range_gen_pkg.sv | 13 +
 rtl/range_counter.sv | 57 +++++
 rtl/dup_range_gen.sv | 112 +++++++++++
 tb/tb_dup_range_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/range_gen_pkg.sv
// Shared types and defaults for the streaming range generator.
package range_gen_pkg;

  localparam int unsigned DefWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StEmit2,
    StDone
  } state_e;

endpackage

// File: rtl/range_counter.sv
// Holds the running element plus the sampled limit/step, and reports whether the
// current and the next element still fall inside the range without wrapping.
module range_counter
  import range_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic                    i_advance,
  input  logic signed [WIDTH-1:0] i_base,
  input  logic signed [WIDTH-1:0] i_limit,
  input  logic signed [WIDTH-1:0] i_step,
  output logic signed [WIDTH-1:0] o_cur,
  output logic signed [WIDTH-1:0] o_next,
  output logic                    o_in_range,
  output logic                    o_next_in_range
);

  localparam logic signed [WIDTH:0] MaxVal = {2'b00, {(WIDTH-1){1'b1}}};

  logic signed [WIDTH-1:0] r_i;
  logic signed [WIDTH-1:0] r_limit;
  logic signed [WIDTH-1:0] r_step;

  logic signed [WIDTH:0] w_sum;
  logic signed [WIDTH:0] w_limit_ext;
  logic                  w_step_pos;
  logic                  w_ovf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_i     <= '0;
      r_limit <= '0;
      r_step  <= '0;
    end else if (i_load) begin
      r_i     <= i_base;
      r_limit <= i_limit;
      r_step  <= i_step;
    end else if (i_advance) begin
      r_i <= w_sum[WIDTH-1:0];
    end
  end

  // The sum is one bit wider so a step past the positive maximum ends the range.
  assign w_sum       = {r_i[WIDTH-1], r_i} + {r_step[WIDTH-1], r_step};
  assign w_limit_ext = {r_limit[WIDTH-1], r_limit};
  assign w_step_pos  = !r_step[WIDTH-1] && (r_step != '0);
  assign w_ovf       = w_sum > MaxVal;

  assign o_cur           = r_i;
  assign o_next          = w_sum[WIDTH-1:0];
  assign o_in_range      = w_step_pos && (r_i < r_limit);
  assign o_next_in_range = w_step_pos && !w_ovf && (w_sum < w_limit_ext);

endmodule

// File: rtl/dup_range_gen.sv
// Streaming range(base, limit, step) source; DUP selects one beat per value on both
// outputs or two consecutive beats per value on _0.
module dup_range_gen
  import range_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter bit          DUP   = 1'b0
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic                    _ready,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  output logic                    _done,
  output logic                    _valid,
  output logic signed [WIDTH-1:0] _0,
  output logic signed [WIDTH-1:0] _1
);

  state_e                  r_state;
  logic                    r_valid;
  logic                    r_done;
  logic signed [WIDTH-1:0] r_out;

  logic                    w_accept;
  logic                    w_advance;
  logic signed [WIDTH-1:0] w_cur;
  logic signed [WIDTH-1:0] w_next;
  logic                    w_in_range;
  logic                    w_next_in_range;

  assign w_accept  = r_valid && _ready && !_start;
  assign w_advance = w_accept &&
                     (((r_state == StEmit) && !DUP) || (r_state == StEmit2));

  range_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .i_clk          (_clock),
    .i_rst          (_reset),
    .i_load         (_start),
    .i_advance      (w_advance),
    .i_base         (base),
    .i_limit        (limit),
    .i_step         (step),
    .o_cur          (w_cur),
    .o_next         (w_next),
    .o_in_range     (w_in_range),
    .o_next_in_range(w_next_in_range)
  );

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      r_state <= StIdle;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
    end else if (_start) begin
      r_state <= StEmit;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: ;
        StEmit: begin
          // r_valid low here means the freshly loaded element has not been examined yet.
          if (!r_valid) begin
            if (w_in_range) begin
              r_valid <= 1'b1;
              r_out   <= w_cur;
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end else if (_ready) begin
            if (DUP) begin
              r_state <= StEmit2;
            end else if (w_next_in_range) begin
              r_out <= w_next;
            end else begin
              r_state <= StDone;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        StEmit2: begin
          if (_ready) begin
            if (w_next_in_range) begin
              r_state <= StEmit;
              r_out   <= w_next;
            end else begin
              r_state <= StDone;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        StDone: ;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign _done  = r_done;
  assign _valid = r_valid;
  assign _0     = r_out;
  assign _1     = DUP ? '0 : r_out;

endmodule

// File: tb/tb_dup_range_gen.sv
// Drives one DUP=0 and one DUP=1 instance with shared stimulus and checks both
// against a queue of values computed directly from range(base, limit, step).
module tb_dup_range_gen;

  localparam int W = 32;
  localparam int MaxBeats = 1024;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic ready;
  logic signed [W-1:0] base_v, limit_v, step_v;

  logic                done_a, valid_a, done_b, valid_b;
  logic signed [W-1:0] out0_a, out1_a, out0_b, out1_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic                s_valid [2];
  logic                s_done  [2];
  logic signed [W-1:0] s_o0    [2];
  logic signed [W-1:0] s_o1    [2];

  longint exp_v  [2][MaxBeats];
  int     exp_n  [2];
  int     exp_idx[2];

  dup_range_gen #(.WIDTH(W), .DUP(1'b0)) u_dut_a (
    ._clock(clk), ._reset(rst), ._start(start), ._ready(ready),
    .base(base_v), .limit(limit_v), .step(step_v),
    ._done(done_a), ._valid(valid_a), ._0(out0_a), ._1(out1_a)
  );

  dup_range_gen #(.WIDTH(W), .DUP(1'b1)) u_dut_b (
    ._clock(clk), ._reset(rst), ._start(start), ._ready(ready),
    .base(base_v), .limit(limit_v), .step(step_v),
    ._done(done_b), ._valid(valid_b), ._0(out0_b), ._1(out1_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic sample();
    s_valid[0] = valid_a; s_done[0] = done_a; s_o0[0] = out0_a; s_o1[0] = out1_a;
    s_valid[1] = valid_b; s_done[1] = done_b; s_o0[1] = out0_b; s_o1[1] = out1_b;
  endtask

  task automatic run_seq(input logic signed [W-1:0] b, input logic signed [W-1:0] l,
                         input logic signed [W-1:0] s, input int pct, input bit stall4);
    bit                  fin    [2];
    bit                  pend   [2];
    bit                  stalled[2];
    logic signed [W-1:0] held   [2];
    int                  stall_cnt;
    bit                  rdy;
    stall_cnt = 0;
    for (int d = 0; d < 2; d++) begin
      fin[d] = 0; pend[d] = 0; stalled[d] = 0; held[d] = '0;
      exp_n[d] = 0; exp_idx[d] = 0;
    end
    // Reference: plain range() in 64-bit arithmetic, so no wrap can occur.
    if (s > 0) begin
      for (longint v = b; v < l; v += s) begin
        exp_v[0][exp_n[0]++] = v;
        exp_v[1][exp_n[1]++] = v;
        exp_v[1][exp_n[1]++] = v;
      end
    end
    @(negedge clk);
    base_v = b; limit_v = l; step_v = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_v = $urandom; limit_v = $urandom; step_v = $urandom;
    sample();
    for (int d = 0; d < 2; d++) begin
      check("start_valid", s_valid[d], 0);
      check("start_done", s_done[d], 0);
    end
    ready = ($urandom_range(0, 99) < pct);
    for (int cyc = 0; cyc < 3000 && !(fin[0] && fin[1]); cyc++) begin
      @(negedge clk);
      sample();
      for (int d = 0; d < 2; d++) begin
        if (!fin[d]) begin
          if (cyc == 0) check("first_valid", s_valid[d], exp_n[d] > 0);
          if (pend[d] || (cyc == 0 && exp_n[d] == 0)) begin
            check("done_rise", s_done[d], 1);
            check("done_valid", s_valid[d], 0);
            fin[d] = 1;
          end else begin
            check("not_done", s_done[d], 0);
            if (stalled[d]) begin
              check("hold_valid", s_valid[d], 1);
              check("hold_data", s_o0[d], held[d]);
            end
          end
        end
      end
      rdy = ($urandom_range(0, 99) < pct);
      if (stall4 && s_valid[0] && s_o0[0] == 4 && stall_cnt < 3) begin
        rdy = 1'b0;
        stall_cnt++;
      end
      ready = rdy;
      for (int d = 0; d < 2; d++) begin
        if (!fin[d] && s_valid[d]) begin
          if (rdy) begin
            if (exp_idx[d] < exp_n[d]) begin
              check("beat_0", s_o0[d], exp_v[d][exp_idx[d]]);
              check("beat_1", s_o1[d], (d == 0) ? exp_v[d][exp_idx[d]] : 64'sd0);
              exp_idx[d]++;
              if (exp_idx[d] == exp_n[d]) pend[d] = 1;
            end else begin
              check("extra_beat", s_valid[d], 0);
            end
            stalled[d] = 0;
          end else begin
            stalled[d] = 1;
            held[d]    = s_o0[d];
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) check("finished", fin[d], 1);
    if (stall4) check("stall_cycles", stall_cnt, 3);
  endtask

  initial begin
    int rb, rl, rs, rp;
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    base_v = '0; limit_v = '0; step_v = '0;
    #12;
    sample();
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", s_valid[d], 0);
      check("rst_done", s_done[d], 0);
      check("rst_o0", s_o0[d], 0);
      check("rst_o1", s_o1[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    run_seq(1, 11, 3, 100, 0);
    run_seq(0, 10, 2, 100, 0);
    run_seq(0, 10, 2, 100, 0);
    run_seq(0, 10, 2, 100, 1);
    run_seq(5, 5, 1, 100, 0);
    run_seq(0, 10, 0, 100, 0);
    run_seq(0, 10, -1, 70, 0);
    run_seq(32'sh7FFF_FFFE, 32'sh7FFF_FFFF, 5, 100, 0);
    run_seq(32'sh7FFF_FFF0, 32'sh7FFF_FFFF, 7, 60, 0);

    // Asynchronous reset in the middle of a sequence, between clock edges.
    @(negedge clk);
    base_v = 100; limit_v = 200; step_v = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ready = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sample();
    for (int d = 0; d < 2; d++) begin
      check("arst_o0", s_o0[d], 0);
      check("arst_o1", s_o1[d], 0);
      check("arst_valid", s_valid[d], 0);
      check("arst_done", s_done[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_seq(0, 4, 1, 100, 0);

    for (int k = 0; k < 20; k++) begin
      rb = int'($urandom_range(0, 100)) - 50;
      rl = int'($urandom_range(0, 150)) - 50;
      rs = int'($urandom_range(0, 13)) - 3;
      rp = int'($urandom_range(30, 100));
      run_seq(rb, rl, rs, rp, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
